mcycle_arbiter: RTL and testbench

- Shares one MCycle multi-cycle multiply/divide unit between two requesters, e.g. the main datapath and a coprocessor/DMA port.
- Grants requesters in round-robin order and latches the winner's operands.
- Sequences the MCycle Start/Busy handshake, captures Result1/Result2 when Busy falls, and returns a per-requester done pulse.
- Includes a watchdog so a hung MCycle cannot deadlock the requesters.

---
 rtl/mcycle_arbiter_pkg.sv | 22 ++
 rtl/mcycle_arbiter_rr_arbiter2.sv | 19 +
 rtl/mcycle_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mcycle_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_arbiter_pkg.sv
// Shared definitions for the two-requester MCycle arbiter:
// MCycleOp encodings, controller states and a counter sizing helper.
package mcycle_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_MUL_S = 2'b00,
        OP_MUL_U = 2'b01,
        OP_DIV_S = 2'b10,
        OP_DIV_U = 2'b11
    } mc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } arb_state_e;

    function automatic int cnt_bits(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/mcycle_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, the requester that was not
// granted last wins a tie.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mcycle_arbiter.sv
// Shares one MCycle multiply/divide unit between two requesters, with
// Start/Busy sequencing, result capture and a timeout watchdog.
module mcycle_arbiter
    import mcycle_arbiter_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int START_TIMEOUT = 4,
    parameter int MAX_CYCLES    = 2 * WIDTH + 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    output logic             done0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic             done1,
    output logic [WIDTH-1:0] res1,
    output logic [WIDTH-1:0] res2,
    output logic             err,
    output logic             mc_start,
    output logic [1:0]       mc_op,
    output logic [WIDTH-1:0] mc_op1,
    output logic [WIDTH-1:0] mc_op2,
    input  logic             mc_busy,
    input  logic [WIDTH-1:0] mc_result1,
    input  logic [WIDTH-1:0] mc_result2
);

    localparam int CW = cnt_bits(START_TIMEOUT, MAX_CYCLES);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            r_last;
    logic            r_owner;
    logic [1:0]      w_grant;
    logic [1:0]      w_ack_nxt;
    logic [1:0]      w_done_nxt;
    logic [1:0]      w_owner_oh;
    logic            w_start_nxt;
    logic            w_err_nxt;
    logic            w_latch;
    logic            w_cap;

    rr_arbiter2 u_rr (
        .i_req   ({req1, req0}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = r_cnt + CW'(1);
        w_ack_nxt   = 2'b00;
        w_done_nxt  = 2'b00;
        w_start_nxt = 1'b0;
        w_err_nxt   = err;
        w_latch     = 1'b0;
        w_cap       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_latch     = 1'b1;
                    w_ack_nxt   = w_grant;
                    w_start_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mc_busy) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end else if (w_cnt_inc == CW'(START_TIMEOUT)) begin
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = w_owner_oh;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_start_nxt = 1'b1;
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_WAIT: begin
                if (!mc_busy) begin
                    w_cap       = 1'b1;
                    w_done_nxt  = w_owner_oh;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_inc == CW'(MAX_CYCLES)) begin
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = w_owner_oh;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands stay on the MCycle bus from one grant until the next.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err      <= 1'b0;
            mc_start <= 1'b0;
            mc_op    <= '0;
            mc_op1   <= '0;
            mc_op2   <= '0;
            res1     <= '0;
            res2     <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            ack0     <= w_ack_nxt[0];
            ack1     <= w_ack_nxt[1];
            done0    <= w_done_nxt[0];
            done1    <= w_done_nxt[1];
            err      <= w_err_nxt;
            mc_start <= w_start_nxt;
            if (w_latch) begin
                r_last  <= w_grant[1];
                r_owner <= w_grant[1];
                mc_op   <= w_grant[1] ? op1 : op0;
                mc_op1  <= w_grant[1] ? a1 : a0;
                mc_op2  <= w_grant[1] ? b1 : b0;
            end
            if (w_cap) begin
                res1 <= mc_result1;
                res2 <= mc_result2;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_arbiter.sv
// Bench for mcycle_arbiter: behavioural MCycle stand-in with stuck-busy
// modes, transaction-level reference model and directed plus random traffic.
module tb_mcycle_arbiter;
    import mcycle_arbiter_pkg::*;

    localparam int W   = 4;
    localparam int ST  = 4;
    localparam int MC  = 2 * W + 4;
    localparam int LAT = 2 * W;

    logic         CLK   = 1'b0;
    logic         RESET = 1'b1;
    logic         req0  = 1'b0;
    logic         req1  = 1'b0;
    logic [1:0]   op0   = '0;
    logic [1:0]   op1   = '0;
    logic [W-1:0] a0    = '0;
    logic [W-1:0] b0    = '0;
    logic [W-1:0] a1    = '0;
    logic [W-1:0] b1    = '0;
    logic         ack0, ack1, done0, done1, err, mc_start, mc_busy;
    logic [1:0]   mc_op;
    logic [W-1:0] res1, res2, mc_op1, mc_op2, mc_result1, mc_result2;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;

    always #5 CLK = ~CLK;

    mcycle_arbiter #(
        .WIDTH(W), .START_TIMEOUT(ST), .MAX_CYCLES(MC)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .ack0(ack0), .done0(done0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .ack1(ack1), .done1(done1),
        .res1(res1), .res2(res2), .err(err),
        .mc_start(mc_start), .mc_op(mc_op),
        .mc_op1(mc_op1), .mc_op2(mc_op2),
        .mc_busy(mc_busy),
        .mc_result1(mc_result1), .mc_result2(mc_result2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {Result2, Result1} from plain integer arithmetic
    function automatic logic [7:0] mc_calc(input logic [1:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        int sa, sb, ua, ub, x, y;
        logic [7:0] r;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        case (op)
            2'b00: begin x = sa * sb; r = x[7:0]; end
            2'b01: begin x = ua * ub; r = x[7:0]; end
            2'b10: begin x = sa / sb; y = sa % sb; r = {y[3:0], x[3:0]}; end
            default: begin x = ua / ub; y = ua % ub; r = {y[3:0], x[3:0]}; end
        endcase
        return r;
    endfunction

    // MCycle stand-in: mode 0 real unit, 1 busy stuck low, 2 busy stuck high
    int         m_cnt = 0;
    logic [7:0] m_res = '0;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_cnt <= 0;
        end else if (mode == 0) begin
            if (m_cnt == 0 && mc_start) begin
                m_cnt <= LAT;
                m_res <= mc_calc(mc_op, mc_op1, mc_op2);
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end
    assign mc_busy = (mode == 2) || (mode == 0 && (m_cnt != 0 || mc_start));
    assign mc_result1 = (mode == 0) ? m_res[3:0] : 4'hA;
    assign mc_result2 = (mode == 0) ? m_res[7:4] : 4'h5;

    // Inputs as seen at each active edge
    logic s_req0, s_req1;
    logic [1:0] s_op0, s_op1;
    logic [3:0] s_a0, s_b0, s_a1, s_b1;
    int s_mode;
    always @(posedge CLK) begin
        s_req0 <= req0; s_req1 <= req1;
        s_op0 <= op0; s_op1 <= op1;
        s_a0 <= a0; s_b0 <= b0; s_a1 <= a1; s_b1 <= b1;
        s_mode <= mode;
    end

    // Transaction-level reference: one operation at a time, fixed timing
    int         cyc = 0;
    bit         rm_idle = 1, rm_last = 1, rm_own = 0, rm_err = 0;
    int         rm_done_at = 0, rm_start_end = 0, rm_mode = 0;
    logic [1:0] rm_op = '0;
    logic [3:0] rm_a = '0, rm_b = '0;
    logic [7:0] rm_res = '0;
    logic [1:0] e_ack, e_done;
    bit         e_start;

    always @(negedge CLK) begin
        if (RESET) begin
            cyc = 0; rm_idle = 1; rm_last = 1; rm_own = 0; rm_err = 0;
            rm_op = '0; rm_a = '0; rm_b = '0; rm_res = '0;
        end else begin
            cyc++;
            e_ack = 2'b00;
            e_done = 2'b00;
            if (rm_idle && (s_req0 || s_req1)) begin
                rm_own = (s_req0 && s_req1) ? !rm_last : s_req1;
                rm_last = rm_own;
                rm_idle = 0;
                rm_op = rm_own ? s_op1 : s_op0;
                rm_a = rm_own ? s_a1 : s_a0;
                rm_b = rm_own ? s_b1 : s_b0;
                rm_mode = s_mode;
                e_ack[rm_own] = 1'b1;
                case (rm_mode)
                    0: begin rm_done_at = cyc + LAT + 2; rm_start_end = cyc; end
                    1: begin rm_done_at = cyc + ST; rm_start_end = cyc + ST - 1; end
                    default: begin rm_done_at = cyc + 1 + MC; rm_start_end = cyc; end
                endcase
            end else if (!rm_idle && cyc == rm_done_at) begin
                e_done[rm_own] = 1'b1;
                if (rm_mode == 0) rm_res = mc_calc(rm_op, rm_a, rm_b);
                else rm_err = 1;
                rm_idle = 1;
            end
            e_start = !rm_idle && cyc <= rm_start_end;
            check("ack", {ack1, ack0}, e_ack);
            check("done", {done1, done0}, e_done);
            check("mc_start", mc_start, e_start);
            check("err", err, rm_err);
            check("res", {res2, res1}, rm_res);
            check("mc_bus", {mc_op, mc_op1, mc_op2}, {rm_op, rm_a, rm_b});
        end
    end

    task automatic wait_evt(input bit want_done, input int maxc,
                            input logic [1:0] exp, input string tag);
        logic [1:0] who;
        who = 2'b00;
        for (int i = 0; i < maxc; i++) begin
            @(negedge CLK);
            #1;
            who = want_done ? {done1, done0} : {ack1, ack0};
            if (who != 2'b00) break;
        end
        check(tag, who, exp);
    endtask

    task automatic op_one(input bit who, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b);
        @(posedge CLK); #2;
        if (who) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
        else begin req0 = 1; op0 = op; a0 = a; b0 = b; end
        wait_evt(0, 4, who ? 2'b10 : 2'b01, "op_ack");
        @(posedge CLK); #2;
        req0 = 0; req1 = 0;
        op0 = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
        op1 = 2'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        wait_evt(1, MC + 8, who ? 2'b10 : 2'b01, "op_done");
    endtask

    task automatic rnd_ops();
        op0 = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
        op1 = 2'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        if (op0[1] && b0 == 0) b0 = 4'd1;
        if (op1[1] && b1 == 0) b1 = 4'd1;
    endtask

    logic [7:0] saved;

    initial begin
        #1;
        check("rst_ackdone", {ack1, ack0, done1, done0}, 0);
        check("rst_start_err", {mc_start, err}, 0);
        check("rst_res", {res2, res1}, 0);
        check("rst_bus", {mc_op, mc_op1, mc_op2}, 0);
        repeat (2) @(negedge CLK);
        #1 RESET = 0;

        op_one(0, 2'b01, 4'hF, 4'hF);
        check("single_res", {res2, res1}, 8'hE1);

        // Contention straight out of reset
        @(posedge CLK); #3;
        RESET = 1;
        req0 = 1; op0 = 2'b11; a0 = 4'd7; b0 = 4'd2;
        req1 = 1; op1 = 2'b11; a1 = 4'd8; b1 = 4'd2;
        @(negedge CLK); #1 RESET = 0;
        wait_evt(0, 4, 2'b01, "cont_ack0");
        @(posedge CLK); #2 req0 = 0;
        wait_evt(1, MC + 8, 2'b01, "cont_done0");
        check("cont_res0", {res2, res1}, 8'h13);
        wait_evt(0, 4, 2'b10, "cont_ack1");
        @(posedge CLK); #2 req1 = 0;
        wait_evt(1, MC + 8, 2'b10, "cont_done1");
        check("cont_res1", {res2, res1}, 8'h04);

        // Fairness with both requests held
        @(posedge CLK); #2;
        req0 = 1; op0 = 2'b01; a0 = 4'd3; b0 = 4'd3;
        req1 = 1; op1 = 2'b00; a1 = 4'd2; b1 = 4'hE;
        for (int k = 0; k < 4; k++)
            wait_evt(0, MC + 8, (k % 2 == 0) ? 2'b01 : 2'b10, "rr_ack");
        @(posedge CLK); #2 req0 = 0; req1 = 0;
        wait_evt(1, MC + 8, 2'b10, "rr_done");
        check("rr_res", {res2, res1}, 8'hFC);

        op_one(1, 2'b00, 4'hF, 4'hF);
        check("smul_res", {res2, res1}, 8'h01);
        op_one(1, 2'b11, 4'hF, 4'h4);
        check("udiv_res", {res2, res1}, 8'h33);

        for (int i = 0; i < 600; i++) begin
            @(posedge CLK); #2;
            req0 = ($urandom_range(0, 2) == 0);
            req1 = ($urandom_range(0, 2) == 0);
            rnd_ops();
        end
        @(posedge CLK); #2 req0 = 0; req1 = 0;
        repeat (MC + 8) @(posedge CLK);

        // Watchdog: busy never rises, then busy never falls
        @(posedge CLK); #2 mode = 1;
        saved = {res2, res1};
        op_one(0, 2'b01, 4'h3, 4'h5);
        check("to_start_err", err, 1);
        check("to_start_res", {res2, res1}, saved);
        @(posedge CLK); #2 mode = 2;
        op_one(1, 2'b01, 4'h6, 4'h7);
        check("to_wait_err", err, 1);
        check("to_wait_res", {res2, res1}, saved);
        @(posedge CLK); #2 mode = 0;
        op_one(0, 2'b01, 4'h2, 4'h3);
        check("err_sticky", err, 1);

        // Asynchronous reset three cycles into an operation
        @(posedge CLK); #2;
        req0 = 1; op0 = 2'b01; a0 = 4'h9; b0 = 4'h9;
        wait_evt(0, 4, 2'b01, "mid_ack");
        req0 = 0;
        repeat (3) @(posedge CLK);
        #3 RESET = 1;
        #1;
        check("mid_rst_pulses", {ack1, ack0, done1, done0}, 0);
        check("mid_rst_start_err", {mc_start, err}, 0);
        check("mid_rst_res", {res2, res1}, 0);
        check("mid_rst_bus", {mc_op, mc_op1, mc_op2}, 0);
        @(negedge CLK); #1 RESET = 0;
        op_one(0, 2'b01, 4'h3, 4'h5);
        check("post_rst_res", {res2, res1}, 8'h0F);
        check("post_rst_err", err, 0);

        repeat (3) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
